// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: initial AddRoundKey, then rounds 1..NR-1
// through a shared middle-round datapath and round NR through the final-round unit.
module aes_round_sequencer #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_data,
  output logic              rnd_in_valid,
  output logic [127:0]      rnd_in_state,
  output logic [127:0]      rnd_round_key,
  input  logic              rnd_out_valid,
  input  logic [127:0]      rnd_out_state,
  output logic              fin_in_valid,
  output logic [127:0]      fin_in_state,
  output logic [127:0]      fin_round_key,
  input  logic              fin_out_valid,
  input  logic [127:0]      fin_out_state,
  output logic              busy,
  output logic [KIDX_W-1:0] round_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FISSUE, S_FWAIT, S_DONE} fsm_t;

  localparam logic [KIDX_W-1:0] LAST_MID = KIDX_W'(NR - 1);
  localparam logic [KIDX_W-1:0] FINAL    = KIDX_W'(NR);

  fsm_t              fsm, fsm_nx;
  logic [127:0]      state_reg, state_reg_nx;
  logic [KIDX_W-1:0] round_cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      round_cnt <= '0;
    end else begin
      fsm       <= fsm_nx;
      state_reg <= state_reg_nx;
      round_cnt <= round_cnt_nx;
    end
  end

  // Done flags are only honoured in the state that waits for them, so stray pulses are dropped.
  always_comb begin
    fsm_nx       = fsm;
    state_reg_nx = state_reg;
    round_cnt_nx = round_cnt;
    case (fsm)
      S_IDLE: if (in_valid) begin
        state_reg_nx = in_block ^ rk_data;
        round_cnt_nx = KIDX_W'(1);
        fsm_nx       = S_ISSUE;
      end
      S_ISSUE:  fsm_nx = S_WAIT;
      S_WAIT: if (rnd_out_valid) begin
        state_reg_nx = rnd_out_state;
        if (round_cnt == LAST_MID) begin
          round_cnt_nx = FINAL;
          fsm_nx       = S_FISSUE;
        end else begin
          round_cnt_nx = round_cnt + KIDX_W'(1);
          fsm_nx       = S_ISSUE;
        end
      end
      S_FISSUE: fsm_nx = S_FWAIT;
      S_FWAIT: if (fin_out_valid) begin
        state_reg_nx = fin_out_state;
        fsm_nx       = S_DONE;
      end
      S_DONE: if (out_ready) begin
        round_cnt_nx = '0;
        fsm_nx       = S_IDLE;
      end
      default: fsm_nx = S_IDLE;
    endcase
  end

  assign in_ready      = (fsm == S_IDLE);
  assign busy          = (fsm != S_IDLE);
  assign rnd_in_valid  = (fsm == S_ISSUE);
  assign fin_in_valid  = (fsm == S_FISSUE);
  assign out_valid     = (fsm == S_DONE);
  assign rk_idx        = round_cnt;
  assign rnd_in_state  = state_reg;
  assign fin_in_state  = state_reg;
  assign out_block     = state_reg;
  assign rnd_round_key = rk_data;
  assign fin_round_key = rk_data;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with behavioural AES round/final-round units
// and a key store expanded from the FIPS-197 App.B key.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int KW = 4;
  localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] RK1   = 128'ha0fafe1788542cb123a339392a6c7605;

  logic clk = 1'b0, reset_n = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_block, out_block, rk_data;
  logic [KW-1:0] rk_idx, round_cnt;
  logic rnd_in_valid, rnd_out_valid, fin_in_valid, fin_out_valid, busy;
  logic [127:0] rnd_in_state, rnd_round_key, rnd_out_state;
  logic [127:0] fin_in_state, fin_round_key, fin_out_state;

  logic [7:0]   sb [256];
  logic [127:0] rk [16];
  int n_assert = 0, n_fail = 0;
  int n_rnd = 0, n_fin = 0;
  int rnd_dly = 1;
  logic spur_rv = 1'b0, spur_fv = 1'b0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .KIDX_W(KW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .rnd_in_valid(rnd_in_valid), .rnd_in_state(rnd_in_state), .rnd_round_key(rnd_round_key),
    .rnd_out_valid(rnd_out_valid), .rnd_out_state(rnd_out_state),
    .fin_in_valid(fin_in_valid), .fin_in_state(fin_in_state), .fin_round_key(fin_round_key),
    .fin_out_valid(fin_out_valid), .fin_out_state(fin_out_state),
    .busy(busy), .round_cnt(round_cnt)
  );

  assign rk_data = rk[rk_idx];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey; byte i = row i%4, column i/4
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit mix);
    logic [7:0] b [16];
    logic [7:0] o [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) o[w+4*c] = sb[b[w+4*((c+w)%4)]];
    if (mix)
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
        o[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
        o[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
        o[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r ^ k;
  endfunction

  // Round unit: result valid rnd_dly cycles after the sampling edge of the request
  logic rnd_pend, model_rv, model_fv;
  int rnd_cd;
  logic [127:0] rnd_res, fin_res;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_rv <= 1'b0; rnd_pend <= 1'b0; rnd_cd <= 0; model_fv <= 1'b0;
    end else begin
      model_rv <= 1'b0;
      model_fv <= 1'b0;
      if (rnd_in_valid) begin
        rnd_res <= aes_round(rnd_in_state, rnd_round_key, 1'b1);
        rnd_cd  <= rnd_dly - 1;
        if (rnd_dly <= 1) model_rv <= 1'b1;
        else rnd_pend <= 1'b1;
      end else if (rnd_pend) begin
        if (rnd_cd <= 1) begin model_rv <= 1'b1; rnd_pend <= 1'b0; end
        rnd_cd <= rnd_cd - 1;
      end
      if (fin_in_valid) begin
        fin_res  <= aes_round(fin_in_state, fin_round_key, 1'b0);
        model_fv <= 1'b1;
      end
    end
  end
  assign rnd_out_valid = model_rv | spur_rv;
  assign rnd_out_state = rnd_res;
  assign fin_out_valid = model_fv | spur_fv;
  assign fin_out_state = fin_res;

  always @(posedge clk) begin
    if (rnd_in_valid === 1'b1) n_rnd++;
    if (fin_in_valid === 1'b1) n_fin++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) @(negedge clk);
    chk(tag, out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, inv, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    int r0, f0;
    bit stable, seen;

    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      inv = 8'h00;
      if (a != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, a);
      end
      sb[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) rk[i] = (i <= NR) ? {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]} : '0;

    in_valid = 1'b0; in_block = '0; out_ready = 1'b1;

    // T1: asynchronous reset mid-cycle
    #13 reset_n = 1'b0;
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_rnd_in_valid", rnd_in_valid, 0);
    chk("t1_fin_in_valid", fin_in_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_rk_idx", rk_idx, 0);
    chk("t1_round_cnt", round_cnt, 0);
    chk("t1_out_block", out_block, 0);
    @(negedge clk) reset_n = 1'b1;

    // T2: FIPS-197 App.B vector, 1-cycle datapaths
    r0 = n_rnd; f0 = n_fin;
    in_valid = 1'b1; in_block = PT;
    @(negedge clk) in_valid = 1'b0;
    chk("t2_rnd_in_valid", rnd_in_valid, 1);
    chk("t2_rnd_in_state", rnd_in_state, R1_IN);
    chk("t2_rnd_round_key", rnd_round_key, RK1);
    chk("t2_in_ready_busy", {in_ready, busy}, 2'b01);
    chk("t2_round_cnt", round_cnt, 1);
    repeat (19) @(negedge clk);
    chk("t2_out_valid_early", out_valid, 0);
    @(negedge clk);
    // high from edge 20, taken at edge 21 after accept
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_block", out_block, CT);
    chk("t2_round_cnt_done", round_cnt, NR);
    @(negedge clk);
    chk("t2_idle_in_ready", in_ready, 1);
    chk("t2_idle_round_cnt", round_cnt, 0);
    chk("t2_rnd_pulses", n_rnd - r0, 9);
    chk("t2_fin_pulses", n_fin - f0, 1);

    // T3: output backpressure with a second block already offered
    out_ready = 1'b0; in_valid = 1'b1; in_block = PT;
    @(negedge clk);
    wait_out("t3_wait1");
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_block !== CT || in_ready !== 1'b0 || rnd_in_valid !== 1'b0) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    chk("t3_out_block", out_block, CT);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_idle_after_hs", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    chk("t3_second_taken", rnd_in_valid, 1);
    in_valid = 1'b0;
    wait_out("t3_wait2");
    chk("t3_out_block2", out_block, CT);
    @(negedge clk);

    // T4: slow round unit
    rnd_dly = 3; r0 = n_rnd; f0 = n_fin;
    in_valid = 1'b1; in_block = PT;
    @(negedge clk) in_valid = 1'b0;
    chk("t4_issue1", rnd_in_valid, 1);
    repeat (3) @(negedge clk);
    chk("t4_hold_wait", {rnd_in_valid, busy, round_cnt}, {1'b0, 1'b1, 4'd1});
    @(negedge clk);
    chk("t4_issue2", {rnd_in_valid, round_cnt}, {1'b1, 4'd2});
    wait_out("t4_wait");
    chk("t4_out_block", out_block, CT);
    @(negedge clk);
    chk("t4_rnd_pulses", n_rnd - r0, 9);
    chk("t4_fin_pulses", n_fin - f0, 1);
    rnd_dly = 1;

    // T5: reset while in round 5, then rerun
    in_valid = 1'b1; in_block = PT;
    @(negedge clk) in_valid = 1'b0;
    for (int i = 0; i < 100 && round_cnt !== 4'd5; i++) @(negedge clk);
    chk("t5_reach_rc5", round_cnt, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_reset_state", {busy, in_ready, out_valid, round_cnt}, {3'b010, 4'd0});
    @(negedge clk) reset_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("t5_no_out_valid", seen, 0);
    in_valid = 1'b1; in_block = PT;
    @(negedge clk) in_valid = 1'b0;
    wait_out("t5_wait");
    chk("t5_out_block", out_block, CT);
    @(negedge clk);

    // T6: stray done pulses in IDLE and DONE, then two back-to-back blocks
    spur_rv = 1'b1; spur_fv = 1'b1;
    @(negedge clk) begin spur_rv = 1'b0; spur_fv = 1'b0; end
    chk("t6_idle_ignored", {busy, in_ready, round_cnt}, {2'b01, 4'd0});
    r0 = n_rnd; f0 = n_fin;
    in_valid = 1'b1; in_block = PT; out_ready = 1'b0;
    @(negedge clk);
    wait_out("t6_wait1");
    spur_rv = 1'b1; spur_fv = 1'b1;
    @(negedge clk) begin spur_rv = 1'b0; spur_fv = 1'b0; end
    chk("t6_done_ignored", {out_valid, round_cnt}, {1'b1, 4'd10});
    chk("t6_out_block1", out_block, CT);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_second_taken", rnd_in_valid, 1);
    in_valid = 1'b0;
    wait_out("t6_wait2");
    chk("t6_out_block2", out_block, CT);
    @(negedge clk);
    chk("t6_rnd_pulses", n_rnd - r0, 18);
    chk("t6_fin_pulses", n_fin - f0, 2);
    chk("t6_final_idle", {busy, in_ready}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
